pwm_ramp_ctrl: RTL and testbench

Sequencer that drives the `duty` input of a `pwm` instance. On a start request it moves the duty value from its current level toward a programmed target in fixed steps, one step every programmed number of clock cycles, and never overshoots. It reports `busy` while ramping and pulses `done` on arrival. Its outputs connect directly to the PWM block: `duty` to `duty` and `ena` to `ena`. Typical uses are LED fade and motor soft-start.

---
 rtl/pwm_ramp_ctrl.sv | 108 ++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp sequencer for a pwm instance: walks duty toward a latched
// target in bounded steps, one step per programmed period, without overshoot.
module pwm_ramp_ctrl #(
  parameter int N = 8,
  parameter int P = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         start,
  input  logic [N-1:0] target,
  input  logic [N-1:0] step,
  input  logic [P-1:0] period,
  output logic [N-1:0] duty,
  output logic         pwm_ena,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

  state_t       state, state_n;
  logic [N-1:0] duty_n, tgt_q, tgt_n, step_q, step_n;
  logic [P-1:0] per_q, per_n, tick, tick_n;
  logic         done_n;
  logic [N:0]   diff_up, diff_dn, stepped;
  logic [N-1:0] duty_step;

  assign pwm_ena = ena;
  assign busy    = (state == RAMP);

  // Differences in N+1 bits so neither direction can wrap.
  always_comb begin
    diff_up   = {1'b0, tgt_q} - {1'b0, duty};
    diff_dn   = {1'b0, duty} - {1'b0, tgt_q};
    stepped   = {1'b0, duty};
    duty_step = duty;
    if (tgt_q > duty) begin
      if (diff_up <= {1'b0, step_q}) duty_step = tgt_q;
      else begin
        stepped   = {1'b0, duty} + {1'b0, step_q};
        duty_step = stepped[N-1:0];
      end
    end else begin
      if (diff_dn <= {1'b0, step_q}) duty_step = tgt_q;
      else begin
        stepped   = {1'b0, duty} - {1'b0, step_q};
        duty_step = stepped[N-1:0];
      end
    end
  end

  always_comb begin
    state_n = state;
    duty_n  = duty;
    tgt_n   = tgt_q;
    step_n  = step_q;
    per_n   = per_q;
    tick_n  = tick;
    done_n  = 1'b0;
    if (ena) begin
      if (start) begin
        tgt_n  = target;
        step_n = (step == '0) ? N'(1) : step;
        per_n  = (period == '0) ? P'(1) : period;
        tick_n = '0;
        if (target == duty) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          state_n = RAMP;
        end
      end else if (state == RAMP) begin
        if (tick == per_q - P'(1)) begin
          tick_n = '0;
          duty_n = duty_step;
          if (duty_step == tgt_q) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end else begin
          tick_n = tick + P'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      duty   <= '0;
      tgt_q  <= '0;
      step_q <= '0;
      per_q  <= '0;
      tick   <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      duty   <= duty_n;
      tgt_q  <= tgt_n;
      step_q <= step_n;
      per_q  <= per_n;
      tick   <= tick_n;
      done   <= done_n;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: a reference model pushes expected
// duty/busy/done per edge into a queue, popped and checked after each edge.
module tb_pwm_ramp_ctrl;

  logic        clk = 1'b0;
  logic        rst, ena, start;
  logic [7:0]  target, step;
  logic [15:0] period;
  logic [7:0]  duty;
  logic        pwm_ena, busy, done;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  int m_duty, m_tgt, m_step, m_per, m_tick;
  bit m_ramp, m_done;
  logic [9:0] exp_q[$];

  pwm_ramp_ctrl #(.N(8), .P(16)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .target(target),
    .step(step), .period(period), .duty(duty), .pwm_ena(pwm_ena),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model(input bit r, input bit e, input bit s,
                       input int t, input int st, input int pe);
    if (r) begin
      m_duty = 0; m_tgt = 0; m_step = 0; m_per = 0; m_tick = 0;
      m_ramp = 0; m_done = 0;
    end else if (!e) begin
      m_done = 0;
    end else begin
      m_done = 0;
      if (s) begin
        m_tgt = t; m_step = (st == 0) ? 1 : st; m_per = (pe == 0) ? 1 : pe;
        m_tick = 0;
        if (t == m_duty) begin m_ramp = 0; m_done = 1; end
        else m_ramp = 1;
      end else if (m_ramp) begin
        if (m_tick == m_per - 1) begin
          m_tick = 0;
          if (m_tgt > m_duty)
            m_duty = (m_tgt - m_duty <= m_step) ? m_tgt : m_duty + m_step;
          else
            m_duty = (m_duty - m_tgt <= m_step) ? m_tgt : m_duty - m_step;
          if (m_duty == m_tgt) begin m_ramp = 0; m_done = 1; end
        end else begin
          m_tick++;
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit s,
                     input int t = 0, input int st = 0, input int pe = 0);
    logic [9:0] ex;
    rst = r; ena = e; start = s;
    target = t[7:0]; step = st[7:0]; period = pe[15:0];
    #1;
    check("pwm_ena", int'(pwm_ena), int'(e));
    model(r, e, s, t, st, pe);
    exp_q.push_back({m_duty[7:0], m_ramp, m_done});
    @(posedge clk);
    #1;
    ex = exp_q.pop_front();
    check("duty", int'(duty), int'(ex[9:2]));
    check("busy", int'(busy), int'(ex[1]));
    check("done", int'(done), int'(ex[0]));
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0);
  endtask

  initial begin
    int n, n_done;
    // reset overrides a simultaneous start
    cyc(1, 1, 1, 50, 5, 1);
    cyc(1, 0, 0);
    check("reset_duty", int'(duty), 0);

    // 0 -> 10, step 3, period 4
    done_cnt = 0;
    cyc(0, 1, 1, 10, 3, 4);
    idle(20);
    check("ramp1_final", int'(duty), 10);
    check("ramp1_done_cnt", done_cnt, 1);

    // trivial request: target equals current duty
    done_cnt = 0;
    cyc(0, 1, 1, 10, 3, 4);
    check("trivial_done", int'(done), 1);
    check("trivial_busy", int'(busy), 0);
    idle(3);
    check("trivial_done_cnt", done_cnt, 1);

    // 10 -> 0, step 4, period 0 (acts as 1)
    done_cnt = 0;
    cyc(0, 1, 1, 0, 4, 0);
    idle(6);
    check("down_final", int'(duty), 0);
    check("down_done_cnt", done_cnt, 1);

    // 0 -> 255, step 100, period 2
    cyc(0, 1, 1, 255, 100, 2);
    idle(10);
    check("full_scale", int'(duty), 255);

    // single-step ramp with maximal step
    cyc(0, 1, 1, 3, 255, 1);
    idle(2);
    check("max_step", int'(duty), 3);

    // mid-ramp retarget
    cyc(1, 1, 0);
    done_cnt = 0;
    cyc(0, 1, 1, 200, 10, 3);
    n = 0;
    while (m_duty != 50 && n < 100) begin cyc(0, 1, 0); n++; end
    check("retarget_reach50", int'(duty), 50);
    cyc(0, 1, 1, 20, 7, 3);
    idle(25);
    check("retarget_final", int'(duty), 20);
    check("retarget_done_cnt", done_cnt, 1);

    // pause with ena low: 20 -> 100 step 10 period 2 finishes at A+21
    cyc(0, 1, 1, 100, 10, 2);
    n = 1; n_done = 0;
    for (int i = 0; i < 3; i++) begin cyc(0, 1, 0); n++; end
    for (int i = 0; i < 5; i++) begin cyc(0, 0, 1, 0, 1, 1); n++; end
    while (n_done == 0 && n < 60) begin
      cyc(0, 1, 0); n++;
      if (done === 1'b1) n_done = n;
    end
    check("pause_latency", n_done, 22);
    check("pause_final", int'(duty), 100);

    // reset mid-ramp
    cyc(0, 1, 1, 200, 5, 1);
    idle(3);
    cyc(1, 1, 0);
    check("rst_mid_duty", int'(duty), 0);
    check("rst_mid_busy", int'(busy), 0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
